// File: rtl/stream_mux_nt1_pkg.sv
// Shared constants and types for the stream multiplexer.
package stream_mux_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_N     = 2;

  // Wide enough to index the largest supported channel count (16)
  localparam int unsigned MAX_SELW = 4;

  typedef logic [MAX_SELW-1:0] grant_idx_t;

endpackage

// File: rtl/stream_mux_nt1_rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the pointer, wrapping.
// Only built when STREAM_MUX_RR_EN is defined.
`ifdef STREAM_MUX_RR_EN
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned SELW = 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [N-1:0]    gnt_oh_c_o,
  output logic [SELW-1:0] gnt_idx_c_o,
  output logic            gnt_vld_c_o
);

  logic            found_hi;
  logic            found_lo;
  logic [SELW-1:0] idx_hi;
  logic [SELW-1:0] idx_lo;

  // Lowest requester above the pointer wins; else lowest at/below it (wrap)
  always_comb begin
    found_hi    = 1'b0;
    found_lo    = 1'b0;
    idx_hi      = '0;
    idx_lo      = '0;
    gnt_vld_c_o = 1'b0;
    gnt_idx_c_o = '0;
    gnt_oh_c_o  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && (32'(ptr_i) < i) && !found_hi) begin
        found_hi = 1'b1;
        idx_hi   = SELW'(i);
      end
      if (req_i[i] && (32'(ptr_i) >= i) && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = SELW'(i);
      end
    end
    gnt_vld_c_o = found_hi || found_lo;
    gnt_idx_c_o = found_hi ? idx_hi : idx_lo;
    for (int unsigned i = 0; i < N; i++) begin
      gnt_oh_c_o[i] = gnt_vld_c_o && (gnt_idx_c_o == SELW'(i));
    end
  end

endmodule
`endif

// File: rtl/stream_mux_nt1.sv
// N-to-1 stream multiplexer with a one-entry registered output.
// Arbitration is fixed (ctrl select) by default; define STREAM_MUX_RR_EN
// for round-robin arbitration, in which case ctrl is ignored.
module stream_mux_nt1
  import stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    ctrl,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_src
);

  logic             load_c;
  logic             gnt_vld_c;
  grant_idx_t       gnt_idx_c;
  logic [WIDTH-1:0] sel_data_c;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_src_q,   out_src_d;

  // Output register can take a word when empty or being drained this cycle
  assign load_c = !out_valid_q || out_ready;

`ifdef STREAM_MUX_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    gnt_oh_c;
  logic [SELW-1:0] rr_idx_c;
  logic            unused_ctrl;

  assign unused_ctrl = ^ctrl;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req_i       (in_valid),
    .ptr_i       (ptr_q),
    .gnt_oh_c_o  (gnt_oh_c),
    .gnt_idx_c_o (rr_idx_c),
    .gnt_vld_c_o (gnt_vld_c)
  );

  assign gnt_idx_c = MAX_SELW'(rr_idx_c);

  // Ready only to the granted channel, and only when the register can load
  always_comb begin
    in_ready = '0;
    if (!rst && load_c) begin
      in_ready = gnt_oh_c;
    end
  end

  // Pointer moves to the winner only when an input transfer happens
  always_comb begin
    ptr_d = ptr_q;
    if (load_c && gnt_vld_c) begin
      ptr_d = rr_idx_c;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= SELW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed select: grant ctrl when it names an existing, valid channel
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ctrl == SELW'(i)) begin
        gnt_vld_c = in_valid[i];
        gnt_idx_c = MAX_SELW'(i);
      end
    end
  end

  // Ready only to the granted channel, and only when the register can load
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = !rst && load_c && gnt_vld_c && (gnt_idx_c == MAX_SELW'(i));
    end
  end
`endif

  // Data of the granted channel
  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_idx_c == MAX_SELW'(i)) begin
        sel_data_c = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next output word: capture on grant, go empty on load without grant
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load_c) begin
      out_valid_d = gnt_vld_c;
      if (gnt_vld_c) begin
        out_data_d = sel_data_c;
        out_src_d  = SELW'(gnt_idx_c);
      end
    end
  end

  // Output register; reset discards any word in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux_nt1.sv
// Self-checking bench for stream_mux_nt1 (N=4, WIDTH=32, SELW=3).
// Follows the same STREAM_MUX_RR_EN setting as the design build.
module tb_stream_mux_nt1;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  ctrl;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_src;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: the one-entry output buffer and the RR pointer
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_src;
  int         m_ptr;

  stream_mux_nt1 #(
    .WIDTH (W),
    .N     (N),
    .SELW  (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit valid_of(input int c);
    return ((in_valid >> c) & 4'b0001) != 4'b0000;
  endfunction

  // Which channel the rules say wins this cycle, -1 for none
  function automatic int ref_grant();
`ifdef STREAM_MUX_RR_EN
    for (int k = 1; k <= int'(N); k++) begin
      int c;
      c = (m_ptr + k) % int'(N);
      if (valid_of(c)) return c;
    end
    return -1;
`else
    if (int'(ctrl) < int'(N)) begin
      if (valid_of(int'(ctrl))) return int'(ctrl);
    end
    return -1;
`endif
  endfunction

  // One clock: check against the model, then advance the model at the edge
  task automatic step();
    int           g;
    bit           ld;
    logic [N-1:0] er;
    #1;
    g  = ref_grant();
    ld = !m_valid || out_ready;
    er = '0;
    if (!rst && ld && g >= 0) er = 4'(1) << g;
    check_eq("in_ready",  64'(in_ready),  64'(er));
    check_eq("out_valid", 64'(out_valid), 64'(m_valid));
    check_eq("out_data",  64'(out_data),  64'(m_data));
    check_eq("out_src",   64'(out_src),   64'(m_src));
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_ptr   = int'(N) - 1;
    end else if (ld) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_data = W'(in_data >> (g * int'(W)));
        m_src  = g;
        m_ptr  = g;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    ctrl      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_ptr   = int'(N) - 1;

    // Reset state
    step();
    check_eq("rst_valid", 64'(out_valid), 64'(0));
    check_eq("rst_data",  64'(out_data),  64'(0));
    rst = 1'b0;

`ifndef STREAM_MUX_RR_EN
    // Single grant on channel 2
    ctrl = 3'd2;
    in_valid = 4'b0100;
    in_data[2*W +: W] = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    #1 check_eq("ch2_rdy", 64'(in_ready), 64'(4'b0100));
    step();
    check_eq("ch2_valid", 64'(out_valid), 64'(1));
    check_eq("ch2_data",  64'(out_data),  64'(32'hDEAD_BEEF));
    check_eq("ch2_src",   64'(out_src),   64'(2));

    // Out-of-range select grants nothing
    ctrl = 3'd5;
    in_valid = 4'b1111;
    #1 check_eq("oor_rdy", 64'(in_ready), 64'(0));
    step();
    check_eq("oor_valid", 64'(out_valid), 64'(0));

    // Backpressure holds the registered word
    ctrl = 3'd0;
    in_valid = 4'b0001;
    in_data[0 +: W] = 32'h11;
    step();
    check_eq("bp_first", 64'(out_data), 64'(32'h11));
    out_ready = 1'b0;
    in_data[0 +: W] = 32'h22;
    for (int i = 0; i < 3; i++) begin
      ctrl = 3'(i);
      #1 check_eq("bp_rdy", 64'(in_ready), 64'(0));
      step();
      check_eq("bp_hold", 64'(out_data), 64'(32'h11));
    end
    ctrl = 3'd0;
    out_ready = 1'b1;
    step();
    check_eq("bp_next",  64'(out_data),  64'(32'h22));
    check_eq("bp_valid", 64'(out_valid), 64'(1));
`endif

    // Reset with a word in flight discards it
    ctrl = 3'd1;
    in_valid = 4'b0010;
    in_data[1*W +: W] = 32'h5A5A_0001;
    step();
    check_eq("pre_rst_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    #1 check_eq("rst_rdy", 64'(in_ready), 64'(0));
    step();
    check_eq("post_rst_valid", 64'(out_valid), 64'(0));
    check_eq("post_rst_data",  64'(out_data),  64'(0));
    rst = 1'b0;

`ifdef STREAM_MUX_RR_EN
    // All valid after reset: sources rotate from 0
    begin
      int seq_a[5] = '{0, 1, 2, 3, 0};
      int seq_b[4] = '{1, 3, 1, 3};
      in_valid = 4'b1111;
      out_ready = 1'b1;
      foreach (seq_a[i]) begin
        step();
        check_eq("rr_rot", 64'(out_src), 64'(seq_a[i]));
      end
      in_valid = 4'b1010;
      foreach (seq_b[i]) begin
        step();
        check_eq("rr_alt", 64'(out_src), 64'(seq_b[i]));
      end
    end
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 39) == 0);
      ctrl      = 3'($urandom_range(0, 7));
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < int'(N); c++) in_data[c*W +: W] = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_nt1.md
STREAM_MUX_NT1 -- requirements
Module: stream_mux_nt1

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel in bits (>=1).
REQ-002 Parameter N, default 2, channel count (2..16).
REQ-003 Parameter SELW, default $clog2(N), select/source index width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  per-channel valid.
REQ-008 in_ready  output  N  per-channel ready, combinational.
REQ-009 ctrl  input  SELW  channel select, used in fixed mode.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_valid  output  1  registered output valid.
REQ-012 out_ready  input  1  downstream ready.
REQ-013 out_src  output  SELW  registered index of the channel that produced out_data.

Function
REQ-014 One-entry output register; a transfer occurs on a side when valid and ready are both high at a clk edge.
REQ-015 load = !out_valid || out_ready; the register accepts new data only when load is high.
REQ-016 Fixed mode: grant = ctrl when ctrl < N and in_valid[ctrl]; no grant when ctrl >= N.
REQ-017 in_ready[i] = load && (grant == i); at most one in_ready bit high per cycle; no in_ready bit depends on in_valid of another channel in fixed mode.
REQ-018 On a grant with load: out_data <= selected channel data, out_src <= grant, out_valid <= 1 on the next edge (latency one cycle).
REQ-019 On load without any grant: out_valid <= 0; out_data and out_src hold.
REQ-020 Full throughput: with out_ready held high and a granted channel valid every cycle, one word per cycle.
REQ-021 out_valid high and out_ready low: out_data, out_src, out_valid hold; all in_ready low.
REQ-022 ctrl change while out_valid stalled does not alter the registered word.

Reset
REQ-023 While rst is high at a clk edge: out_valid <= 0, out_data <= 0, out_src <= 0, round-robin pointer <= N-1.
REQ-024 in_ready is forced to all-zero while rst is high; a word in flight at reset is discarded.

Configuration
REQ-025 Macro STREAM_MUX_RR_EN defined: arbitration is round-robin; ctrl is ignored.
REQ-026 RR grant = first channel with in_valid set, searching from pointer+1 upward with wrap from N-1 to 0.
REQ-027 RR pointer updates to the granted index only on an input transfer; otherwise holds.
REQ-028 Macro undefined: fixed mode per REQ-016; no pointer register is generated.

Structure
REQ-029 Shared package stream_mux_pkg holds default WIDTH/N constants and the grant-index typedef.
REQ-030 One sub-module, rr_arbiter (N-bit request, pointer in, one-hot/index grant out), instantiated only under STREAM_MUX_RR_EN.

Verification
REQ-031 Fixed, N=4, ctrl=2, in_valid=4'b0100, in_data ch2=0xDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=0xDEADBEEF, out_src=2.
REQ-032 Fixed, ctrl=5 with N=4, all valid -> in_ready=0; out_valid falls to 0 after one cycle.
REQ-033 Backpressure: word 0x11 held, out_ready=0 for 3 cycles, ch data changes to 0x22 -> out_data stays 0x11, in_ready=0 throughout; out_ready=1 -> 0x22 registered next cycle.
REQ-034 RR, N=4, all valid, out_ready=1 after reset -> out_src sequence 0,1,2,3,0.
REQ-035 RR, in_valid=4'b1010, pointer=1 -> grant 3, then 1, alternating.
REQ-036 rst asserted while out_valid=1 -> next cycle out_valid=0, out_data=0, in_ready=0 during reset.
